// File: rtl/decode_stage.sv
// RV32I/M instruction decoder feeding a small output FIFO.
// Decode is combinational on the offered instruction; the result is buffered with its PC.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter int ENABLE_M = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_alu_ctr,
  output logic            out_alu_b_ctr,
  output logic [3:0]      out_bxx,
  output logic            out_jal,
  output logic            out_jalr,
  output logic            out_reg_we,
  output logic            out_mem_we,
  output logic [2:0]      out_mem2reg,
  output logic [2:0]      out_mem_opr,
  output logic [3:0]      out_mem_opw,
  output logic            out_illegal
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_SLT  = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_SRA  = 5'b01101;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      alu_ctr;
    logic            alu_b_ctr;
    logic [3:0]      bxx;
    logic            jal;
    logic            jalr;
    logic            reg_we;
    logic            mem_we;
    logic [2:0]      mem2reg;
    logic [2:0]      mem_opr;
    logic [3:0]      mem_opw;
    logic            illegal;
  } entry_t;

  function automatic logic [3:0] byte_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  fun3;
  logic [6:0]  fun7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm32;
  entry_t      dec;

  assign opcode = in_instr[6:0];
  assign fun3   = in_instr[14:12];
  assign fun7   = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  always_comb begin
    dec           = '0;
    imm32         = '0;
    dec.pc        = in_pc;
    dec.rd        = in_instr[11:7];
    dec.rs1       = in_instr[19:15];
    dec.rs2       = in_instr[24:20];
    dec.alu_ctr   = ALU_ADD;
    dec.alu_b_ctr = 1'b1;

    case (opcode)
      OPC_LUI: begin
        dec.reg_we  = 1'b1;
        dec.mem2reg = 3'b011;
        imm32       = imm_u;
      end
      OPC_AUIPC: begin
        dec.reg_we  = 1'b1;
        dec.mem2reg = 3'b100;
        imm32       = imm_u;
      end
      OPC_JAL: begin
        dec.jal     = 1'b1;
        dec.reg_we  = 1'b1;
        dec.mem2reg = 3'b010;
        imm32       = imm_j;
      end
      OPC_JALR: begin
        dec.jalr    = 1'b1;
        dec.reg_we  = 1'b1;
        dec.mem2reg = 3'b010;
        imm32       = imm_i;
        dec.illegal = (fun3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.alu_b_ctr = 1'b0;
        dec.bxx       = {1'b1, fun3};
        imm32         = imm_b;
        case (fun3[2:1])
          2'b00:   dec.alu_ctr = ALU_SUB;
          2'b10:   dec.alu_ctr = ALU_SLT;
          2'b11:   dec.alu_ctr = ALU_SLTU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.reg_we  = 1'b1;
        dec.mem2reg = 3'b001;
        dec.mem_opr = fun3;
        dec.mem_opw = byte_mask(fun3[1:0]);
        imm32       = imm_i;
        dec.illegal = (fun3[1:0] == 2'b11) || (fun3 == 3'b110);
      end
      OPC_STORE: begin
        dec.mem_we  = 1'b1;
        dec.mem_opw = byte_mask(fun3[1:0]);
        imm32       = imm_s;
        dec.illegal = fun3[2] || (fun3[1:0] == 2'b11);
      end
      OPC_IMM: begin
        dec.reg_we  = 1'b1;
        dec.alu_ctr = {2'b00, fun3};
        imm32       = imm_i;
        // Shift-immediates carry fun7 in the upper immediate bits.
        if (fun3 == 3'b001) begin
          dec.illegal = (fun7 != F7_BASE);
        end else if (fun3 == 3'b101) begin
          if (fun7 == F7_ALT)
            dec.alu_ctr = ALU_SRA;
          else if (fun7 != F7_BASE)
            dec.illegal = 1'b1;
        end
      end
      OPC_REG: begin
        dec.reg_we    = 1'b1;
        dec.alu_b_ctr = 1'b0;
        if (fun7 == F7_BASE)
          dec.alu_ctr = {2'b00, fun3};
        else if ((fun7 == F7_ALT) && ((fun3 == 3'b000) || (fun3 == 3'b101)))
          dec.alu_ctr = {2'b01, fun3};
        else if ((fun7 == F7_MUL) && (ENABLE_M != 0))
          dec.alu_ctr = {2'b10, fun3};
        else
          dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase

    dec.imm = (dec.illegal || opcode == OPC_REG) ? '0 : XLEN'($signed(imm32));
    if (dec.illegal) begin
      dec.reg_we = 1'b0;
      dec.mem_we = 1'b0;
      dec.jal    = 1'b0;
      dec.jalr   = 1'b0;
      dec.bxx[3] = 1'b0;
    end
  end

  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  entry_t        mem [DEPTH];
  entry_t        head;

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  // Flush wins over both ends: nothing enters or leaves in a flush cycle.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push)
      mem[wr_ptr] <= dec;
  end

  assign head = mem[rd_ptr];

  assign out_pc        = head.pc;
  assign out_imm       = head.imm;
  assign out_rd        = head.rd;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  // Stale payload may sit in the buffer; control fields are masked when empty.
  assign out_alu_ctr   = out_valid ? head.alu_ctr   : '0;
  assign out_alu_b_ctr = out_valid ? head.alu_b_ctr : 1'b0;
  assign out_bxx       = out_valid ? head.bxx       : '0;
  assign out_jal       = out_valid ? head.jal       : 1'b0;
  assign out_jalr      = out_valid ? head.jalr      : 1'b0;
  assign out_reg_we    = out_valid ? head.reg_we    : 1'b0;
  assign out_mem_we    = out_valid ? head.mem_we    : 1'b0;
  assign out_mem2reg   = out_valid ? head.mem2reg   : '0;
  assign out_mem_opr   = out_valid ? head.mem_opr   : '0;
  assign out_mem_opw   = out_valid ? head.mem_opw   : '0;
  assign out_illegal   = out_valid ? head.illegal   : 1'b0;

endmodule
